// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl
// Frame controller sitting behind a UART receiver. It hunts for a sync byte,
// reads a length byte and up to MAX_LEN payload bytes into a local buffer,
// then replays the payload to a downstream valid/ready byte stream.
// Bad length, inter-byte timeout, overrun and check mismatch each raise a
// one-cycle PktError pulse with the cause held on ErrCode.
//
// Build option: define UART_FRAME_CHECK_EN to expect a trailing check byte
// (XOR of the length byte and every payload byte) after the payload. With the
// macro undefined the last payload byte moves straight to DRAIN.

module uart_rx_frame_ctrl #(
    parameter int                   DATA_BITS     = 8,
    parameter int                   MAX_LEN       = 16,
    parameter logic [DATA_BITS-1:0] SYNC_BYTE     = 8'hA5,
    parameter int                   TIMEOUT_TICKS = 480
) (
    input  logic                           Clock,
    input  logic                           ResetN,
    input  logic                           Tick,
    input  logic                           RxReady,
    input  logic [DATA_BITS-1:0]           RxData,
    output logic                           PktValid,
    input  logic                           PktReady,
    output logic [DATA_BITS-1:0]           PktData,
    output logic                           PktLast,
    output logic [$clog2(MAX_LEN+1)-1:0]   PktLen,
    output logic                           PktError,
    output logic [1:0]                     ErrCode,
    output logic                           Busy
);

    // ------------------------------------------------------------------
    // Derived widths and constants
    // ------------------------------------------------------------------
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TO_W  = $clog2(TIMEOUT_TICKS + 1);

    localparam logic [DATA_BITS-1:0] MAX_LEN_B = DATA_BITS'(MAX_LEN);
    localparam logic [TO_W-1:0]      TO_LAST   = TO_W'(TIMEOUT_TICKS - 1);
    localparam logic [LEN_W-1:0]     LEN_ONE   = LEN_W'(1);

    // Frame state encoding
    localparam logic [2:0] S_HUNT    = 3'd0;
    localparam logic [2:0] S_LEN     = 3'd1;
    localparam logic [2:0] S_PAYLOAD = 3'd2;
    localparam logic [2:0] S_CHECK   = 3'd3;
    localparam logic [2:0] S_DRAIN   = 3'd4;

    // Error causes reported on ErrCode
    localparam logic [1:0] E_LEN     = 2'd0;
    localparam logic [1:0] E_TIMEOUT = 2'd1;
`ifdef UART_FRAME_CHECK_EN
    localparam logic [1:0] E_CHECK   = 2'd2;
`endif
    localparam logic [1:0] E_OVERRUN = 2'd3;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [2:0]           r_state;
    logic                 r_busy;
    logic                 r_pkt_valid;
    logic                 r_pkt_error;
    logic [1:0]           r_err_code;
    logic [DATA_BITS-1:0] r_pkt_data;
    logic                 r_pkt_last;
    logic [LEN_W-1:0]     r_pkt_len;

    logic [LEN_W-1:0]     r_len;
    logic [LEN_W-1:0]     r_wr;
    logic [LEN_W-1:0]     r_rd;
    logic [TO_W-1:0]      r_to_cnt;

    logic [DATA_BITS-1:0] r_buf [MAX_LEN];

`ifdef UART_FRAME_CHECK_EN
    logic [DATA_BITS-1:0] r_chk;
`endif

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic [2:0]       w_state_nxt;
    logic             w_err_fire;
    logic [1:0]       w_err_code;
    logic             w_timed;
    logic             w_to_expire;
    logic             w_len_ok;
    logic             w_last_payload;
    logic             w_buf_we;
    logic             w_handshake;
    logic             w_drain_enter;
    logic [LEN_W-1:0] w_len_m1;
    logic [LEN_W-1:0] w_rd_inc;

    assign w_timed        = (r_state == S_LEN) || (r_state == S_PAYLOAD) || (r_state == S_CHECK);
    // A byte in the same cycle as the terminal Tick keeps the frame alive.
    assign w_to_expire    = w_timed && Tick && !RxReady && (r_to_cnt == TO_LAST);
    assign w_len_ok       = (RxData != '0) && (RxData <= MAX_LEN_B);
    assign w_len_m1       = r_len - LEN_ONE;
    assign w_last_payload = (r_wr == w_len_m1);
    assign w_buf_we       = (r_state == S_PAYLOAD) && RxReady;
    assign w_handshake    = (r_state == S_DRAIN) && r_pkt_valid && PktReady;
    assign w_rd_inc       = r_rd + LEN_ONE;
    assign w_drain_enter  = (w_state_nxt == S_DRAIN) && (r_state != S_DRAIN);

    // Next-state and error-cause selection for the frame FSM.
    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves one unassigned and infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_err_fire  = 1'b0;
        w_err_code  = E_LEN;
        case (r_state)
            S_HUNT: begin
                if (RxReady && (RxData == SYNC_BYTE)) begin
                    w_state_nxt = S_LEN;
                end
            end
            S_LEN: begin
                if (RxReady) begin
                    if (w_len_ok) begin
                        w_state_nxt = S_PAYLOAD;
                    end else begin
                        w_err_fire  = 1'b1;
                        w_err_code  = E_LEN;
                        w_state_nxt = S_HUNT;
                    end
                end else if (w_to_expire) begin
                    w_err_fire  = 1'b1;
                    w_err_code  = E_TIMEOUT;
                    w_state_nxt = S_HUNT;
                end
            end
            S_PAYLOAD: begin
                if (RxReady) begin
                    if (w_last_payload) begin
`ifdef UART_FRAME_CHECK_EN
                        w_state_nxt = S_CHECK;
`else
                        w_state_nxt = S_DRAIN;
`endif
                    end
                end else if (w_to_expire) begin
                    w_err_fire  = 1'b1;
                    w_err_code  = E_TIMEOUT;
                    w_state_nxt = S_HUNT;
                end
            end
`ifdef UART_FRAME_CHECK_EN
            S_CHECK: begin
                if (RxReady) begin
                    if (RxData == r_chk) begin
                        w_state_nxt = S_DRAIN;
                    end else begin
                        w_err_fire  = 1'b1;
                        w_err_code  = E_CHECK;
                        w_state_nxt = S_HUNT;
                    end
                end else if (w_to_expire) begin
                    w_err_fire  = 1'b1;
                    w_err_code  = E_TIMEOUT;
                    w_state_nxt = S_HUNT;
                end
            end
`endif
            S_DRAIN: begin
                // A byte arriving while draining is dropped; draining carries on.
                if (RxReady) begin
                    w_err_fire = 1'b1;
                    w_err_code = E_OVERRUN;
                end
                if (w_handshake && r_pkt_last) begin
                    w_state_nxt = S_HUNT;
                end
            end
            default: begin
                w_state_nxt = S_HUNT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // FSM state plus the registered status outputs derived from it.
    // NOTE: sequential state is always updated with non-blocking assignments
    // so every register samples pre-edge values regardless of block order.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            r_state     <= S_HUNT;
            r_busy      <= 1'b0;
            r_pkt_valid <= 1'b0;
            r_pkt_error <= 1'b0;
            r_err_code  <= E_LEN;
        end else begin
            r_state     <= w_state_nxt;
            r_busy      <= (w_state_nxt != S_HUNT);
            r_pkt_valid <= (w_state_nxt == S_DRAIN);
            r_pkt_error <= w_err_fire;
            if (w_err_fire) begin
                r_err_code <= w_err_code;
            end
        end
    end

    // Frame bookkeeping: latched length, write/read indices, inter-byte timer.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            r_len    <= '0;
            r_wr     <= '0;
            r_rd     <= '0;
            r_to_cnt <= '0;
        end else begin
            if ((r_state == S_LEN) && RxReady && w_len_ok) begin
                r_len <= LEN_W'(RxData);
                r_wr  <= '0;
            end else if (w_buf_we) begin
                r_wr <= r_wr + LEN_ONE;
            end

            if (w_drain_enter) begin
                r_rd <= '0;
            end else if (w_handshake) begin
                r_rd <= w_rd_inc;
            end

            if (!w_timed || RxReady || w_to_expire) begin
                r_to_cnt <= '0;
            end else if (Tick) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end
        end
    end

`ifdef UART_FRAME_CHECK_EN
    // Running XOR of the length byte and every payload byte.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            r_chk <= '0;
        end else if ((r_state == S_LEN) && RxReady && w_len_ok) begin
            r_chk <= RxData;
        end else if (w_buf_we) begin
            r_chk <= r_chk ^ RxData;
        end
    end
`endif

    // Payload buffer write port.
    // NOTE: the buffer is deliberately left out of reset; the indices and the
    // valid flag gate every read, so stale contents are never presented.
    always_ff @(posedge Clock) begin
        if (w_buf_we) begin
            r_buf[r_wr[IDX_W-1:0]] <= RxData;
        end
    end

    // Output byte stage: loads the first byte on DRAIN entry, advances per handshake.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            r_pkt_data <= '0;
            r_pkt_last <= 1'b0;
            r_pkt_len  <= '0;
        end else if (w_drain_enter) begin
            r_pkt_len  <= r_len;
            r_pkt_last <= (r_len == LEN_ONE);
            // A one-byte frame without a check byte finishes on the very strobe
            // that writes buf[0], so that byte is forwarded straight from RxData.
            if ((r_state == S_PAYLOAD) && (r_wr == '0)) begin
                r_pkt_data <= RxData;
            end else begin
                r_pkt_data <= r_buf[0];
            end
        end else if (w_handshake) begin
            if (r_pkt_last) begin
                r_pkt_last <= 1'b0;
            end else begin
                r_pkt_data <= r_buf[w_rd_inc[IDX_W-1:0]];
                r_pkt_last <= (w_rd_inc == w_len_m1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Output wiring
    // ------------------------------------------------------------------
    assign PktValid = r_pkt_valid;
    assign PktData  = r_pkt_data;
    assign PktLast  = r_pkt_last;
    assign PktLen   = r_pkt_len;
    assign PktError = r_pkt_error;
    assign ErrCode  = r_err_code;
    assign Busy     = r_busy;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl
// Directed bench for uart_rx_frame_ctrl with hand-computed expectations.
// Inputs change on the falling edge and outputs are sampled on the falling
// edge, half a cycle away from the capturing rising edge. Check bytes are
// sent only when UART_FRAME_CHECK_EN is defined for the build.

module tb_uart_rx_frame_ctrl;

    logic       Clock    = 1'b0;
    logic       ResetN   = 1'b0;
    logic       Tick     = 1'b0;
    logic       RxReady  = 1'b0;
    logic [7:0] RxData   = 8'h00;
    logic       PktReady = 1'b0;

    logic       PktValid;
    logic [7:0] PktData;
    logic       PktLast;
    logic [4:0] PktLen;
    logic       PktError;
    logic [1:0] ErrCode;
    logic       Busy;

    int n_checks = 0;
    int n_errors = 0;
    int err_seen = 0;

    uart_rx_frame_ctrl #(
        .DATA_BITS     (8),
        .MAX_LEN       (16),
        .SYNC_BYTE     (8'hA5),
        .TIMEOUT_TICKS (480)
    ) dut (
        .Clock    (Clock),
        .ResetN   (ResetN),
        .Tick     (Tick),
        .RxReady  (RxReady),
        .RxData   (RxData),
        .PktValid (PktValid),
        .PktReady (PktReady),
        .PktData  (PktData),
        .PktLast  (PktLast),
        .PktLen   (PktLen),
        .PktError (PktError),
        .ErrCode  (ErrCode),
        .Busy     (Busy)
    );

    always #5 Clock = ~Clock;

    // Count error pulses using the pre-edge value seen at each rising edge.
    always @(posedge Clock) begin
        if (PktError) err_seen++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one byte for exactly one cycle; returns on the following falling edge.
    task automatic send_byte(input logic [7:0] b);
        RxData  = b;
        RxReady = 1'b1;
        @(negedge Clock);
        RxReady = 1'b0;
    endtask

    // Apply n consecutive Tick cycles with no byte.
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            Tick = 1'b1;
            @(negedge Clock);
        end
        Tick = 1'b0;
    endtask

    // Sync, length, payload[i] = base + i*step, then the check byte if enabled.
    task automatic send_frame(input int len, input logic [7:0] base, input logic [7:0] step);
        logic [7:0] chk;
        logic [7:0] b;
        chk = 8'(len);
        send_byte(8'hA5);
        send_byte(8'(len));
        for (int i = 0; i < len; i++) begin
            b   = 8'(base + 8'(i) * step);
            chk = chk ^ b;
            send_byte(b);
        end
`ifdef UART_FRAME_CHECK_EN
        send_byte(chk);
`endif
    endtask

    // Safety net in case the run ever stalls.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int err_base;

        // ---------------- reset state ----------------
        #3;
        check("rst_busy",  Busy,     0);
        check("rst_valid", PktValid, 0);
        check("rst_err",   PktError, 0);
        check("rst_code",  ErrCode,  0);
        check("rst_len",   PktLen,   0);
        check("rst_data",  PktData,  0);
        check("rst_last",  PktLast,  0);
        @(negedge Clock);
        ResetN = 1'b1;
        @(negedge Clock);

        // ---------------- 1: A5 03 11 22 33, PktReady held high ----------------
        err_base = err_seen;
        PktReady = 1'b1;
        send_byte(8'hA5);
        check("t1_busy_after_sync", Busy, 1);
        send_frame_tail_3();
        check("t1_valid0", PktValid, 1);
        check("t1_data0",  PktData,  8'h11);
        check("t1_last0",  PktLast,  0);
        check("t1_len",    PktLen,   3);
        @(negedge Clock);
        check("t1_data1",  PktData,  8'h22);
        check("t1_last1",  PktLast,  0);
        @(negedge Clock);
        check("t1_data2",  PktData,  8'h33);
        check("t1_last2",  PktLast,  1);
        check("t1_len_hold", PktLen, 3);
        @(negedge Clock);
        check("t1_valid_end", PktValid, 0);
        check("t1_busy_end",  Busy,     0);
        @(negedge Clock);
        check("t1_no_err", err_seen - err_base, 0);

        // ---------------- 3: timeout, incl. byte on the terminal Tick ----------------
        send_byte(8'hA5);
        ticks(479);
        Tick = 1'b1;
        send_byte(8'h02);
        Tick = 1'b0;
        check("t3_byte_wins_busy", Busy,     1);
        check("t3_byte_wins_err",  PktError, 0);
        send_byte(8'hAA);
        err_base = err_seen;
        ticks(479);
        check("t3_busy_479",   Busy, 1);
        check("t3_no_err_479", err_seen - err_base, 0);
        ticks(1);
        check("t3_err",  PktError, 1);
        check("t3_code", ErrCode,  1);
        check("t3_busy", Busy,     0);
        @(negedge Clock);
        check("t3_err_one_cycle", PktError, 0);
        check("t3_code_held",     ErrCode,  1);

        // ---------------- 2: junk ignored, zero length rejected ----------------
        send_byte(8'h00);
        check("t2_busy_00", Busy, 0);
        send_byte(8'h7E);
        check("t2_busy_7e", Busy, 0);
        send_byte(8'hA5);
        check("t2_busy_a5", Busy, 1);
        send_byte(8'h00);
        check("t2_err",  PktError, 1);
        check("t2_code", ErrCode,  0);
        check("t2_busy", Busy,     0);

        // ---------------- 5: overrun while stalled ----------------
        PktReady = 1'b0;
        send_frame(2, 8'h10, 8'h10);
        check("t5_valid", PktValid, 1);
        check("t5_data0", PktData,  8'h10);
        check("t5_last0", PktLast,  0);
        check("t5_len",   PktLen,   2);
        send_byte(8'hA5);
        check("t5_err",        PktError, 1);
        check("t5_code",       ErrCode,  3);
        check("t5_data_hold",  PktData,  8'h10);
        check("t5_valid_hold", PktValid, 1);
        @(negedge Clock);
        @(negedge Clock);
        check("t5_err_cleared", PktError, 0);
        check("t5_data_stall",  PktData,  8'h10);
        PktReady = 1'b1;
        @(negedge Clock);
        check("t5_data1", PktData, 8'h20);
        check("t5_last1", PktLast, 1);
        @(negedge Clock);
        check("t5_valid_end", PktValid, 0);
        send_byte(8'h03);
        check("t5_sync_not_kept", Busy, 0);

        // ---------------- length just above MAX_LEN rejected ----------------
        send_byte(8'hA5);
        send_byte(8'h11);
        check("len17_err",  PktError, 1);
        check("len17_code", ErrCode,  0);
        check("len17_busy", Busy,     0);

        // ---------------- full MAX_LEN frame ----------------
        PktReady = 1'b1;
        send_frame(16, 8'h40, 8'h01);
        check("max_len", PktLen, 16);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("max_data%0d", i), PktData, 8'(8'h40 + i));
            check($sformatf("max_last%0d", i), PktLast, (i == 15) ? 1 : 0);
            @(negedge Clock);
        end
        check("max_valid_end", PktValid, 0);

`ifdef UART_FRAME_CHECK_EN
        // ---------------- 4: check byte mismatch ----------------
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h55);
        send_byte(8'h00);
        check("t4_err",   PktError, 1);
        check("t4_code",  ErrCode,  2);
        check("t4_valid", PktValid, 0);
        @(negedge Clock);
        check("t4_valid_later", PktValid, 0);
        check("t4_busy",        Busy,     0);
`endif

        // ---------------- 6: reset mid-PAYLOAD ----------------
        send_byte(8'hA5);
        send_byte(8'h04);
        send_byte(8'h01);
        check("t6_busy_before", Busy, 1);
        #2;
        ResetN = 1'b0;
        #1;
        check("t6_rst_busy",  Busy,     0);
        check("t6_rst_valid", PktValid, 0);
        check("t6_rst_err",   PktError, 0);
        check("t6_rst_code",  ErrCode,  0);
        check("t6_rst_len",   PktLen,   0);
        check("t6_rst_data",  PktData,  0);
        check("t6_rst_last",  PktLast,  0);
        @(negedge Clock);
        ResetN = 1'b1;
        @(negedge Clock);
        err_base = err_seen;
        PktReady = 1'b1;
        send_frame(1, 8'h99, 8'h00);
        check("t6_valid", PktValid, 1);
        check("t6_data",  PktData,  8'h99);
        check("t6_last",  PktLast,  1);
        check("t6_len",   PktLen,   1);
        @(negedge Clock);
        check("t6_valid_end", PktValid, 0);
        check("t6_busy_end",  Busy,     0);
        @(negedge Clock);
        check("t6_no_err", err_seen - err_base, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Remainder of the test-1 frame after the sync byte: 03 11 22 33 (+03).
    task automatic send_frame_tail_3();
        send_byte(8'h03);
        check("t1_busy_after_len", Busy, 1);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
`ifdef UART_FRAME_CHECK_EN
        send_byte(8'h03);
`endif
    endtask

endmodule
